// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared definitions for the sprite motion controller: FSM encoding,
// default VGA geometry, default sprite colour and per-axis step helper.
package sprite_motion_ctrl_pkg;

  localparam int         H_ACTIVE_DEF  = 640;
  localparam int         V_ACTIVE_DEF  = 480;
  localparam logic [2:0] SPR_COLOR_DEF = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_MOVE_X,
    ST_MOVE_Y,
    ST_COMMIT
  } state_e;

  // Result of moving one axis for one frame.
  typedef struct packed {
    logic [9:0] pos;
    logic       bnc;   // auto-mode bounce happened on this axis
  } axis_t;

  // One frame of motion on one axis. Arithmetic is 11-bit signed so that
  // stepping below zero clamps to zero instead of wrapping.
  function automatic axis_t axis_step(input logic [9:0]         pos,
                                      input logic               dir,
                                      input logic               auto_mode,
                                      input logic               inc,
                                      input logic               dec,
                                      input logic signed [10:0] lim,
                                      input logic signed [10:0] step);
    logic signed [10:0] s;
    axis_t              r;
    s = $signed({1'b0, pos});
    if (auto_mode)      s = dir ? s + step : s - step;
    else if (inc && !dec) s = s + step;
    else if (dec && !inc) s = s - step;
    r.pos = s[9:0];
    r.bnc = 1'b0;
    if (s >= lim) begin
      r.pos = lim[9:0];
      r.bnc = auto_mode && dir;
    end else if (s <= 11'sd0) begin
      r.pos = '0;
      r.bnc = auto_mode && !dir;
    end
    return r;
  endfunction

  // Advance colour mod 8, skipping the background colour.
  function automatic logic [2:0] next_color(input logic [2:0] c,
                                            input logic [2:0] back);
    logic [2:0] n;
    n = c + 3'd1;
    if (n == back) n = n + 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_tick.sv
// Frame tick generator: one-cycle pulse on the rising edge of
// "first blanking row, column 0". Reusable by other VGA blocks.
module frame_tick_gen
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [9:0] iColumnCount,
  input  logic [9:0] iRowCount,
  output logic       oTick
);

  logic w_cond;
  logic r_cond_d;

  assign w_cond = (iRowCount == 10'(V_ACTIVE)) && (iColumnCount == 10'd0);

  // Delay stage for edge detection; held counts keep this high so no retick.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_cond_d <= 1'b0;
    else        r_cond_d <= w_cond;
  end

  assign oTick = w_cond & ~r_cond_d;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite motion controller: once per frame samples buttons/mode, moves the
// sprite on X then Y with clamping or bouncing, and publishes the new
// position, enable and colour together at the end of the sequence.
module sprite_motion_ctrl
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int SPR_SIZE = 16,
  parameter int STEP     = 2,
  parameter int X_INIT   = 312,
  parameter int Y_INIT   = 232
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [9:0] iColumnCount,
  input  logic [9:0] iRowCount,
  input  logic       iUp,
  input  logic       iDown,
  input  logic       iLeft,
  input  logic       iRight,
  input  logic       iAuto,
  input  logic       iEnableReq,
  input  logic [2:0] iColorBack,
  output logic [9:0] oPosX,
  output logic [9:0] oPosY,
  output logic       oEnable,
  output logic [2:0] oColorSprite,
  output logic       oBusy
);

  localparam logic signed [10:0] X_MAX  = 11'(H_ACTIVE - SPR_SIZE);
  localparam logic signed [10:0] Y_MAX  = 11'(V_ACTIVE - SPR_SIZE);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  state_e     r_state;
  logic       r_up, r_dn, r_lf, r_rt, r_auto, r_en_req;
  logic [9:0] r_x, r_y;           // working position
  logic       r_dir_x, r_dir_y;   // 1 = increasing
  logic       r_bnc;              // any bounce seen this frame
  logic [9:0] r_pos_x, r_pos_y;
  logic       r_enable;
  logic [2:0] r_color;
  logic       r_busy;
  logic       w_tick;
  axis_t      w_ax, w_ay;

  frame_tick_gen #(.V_ACTIVE(V_ACTIVE)) u_tick (
    .Clock        (Clock),
    .Reset        (Reset),
    .iColumnCount (iColumnCount),
    .iRowCount    (iRowCount),
    .oTick        (w_tick)
  );

  assign w_ax = axis_step(r_x, r_dir_x, r_auto, r_rt, r_lf, X_MAX, STEP_S);
  assign w_ay = axis_step(r_y, r_dir_y, r_auto, r_dn, r_up, Y_MAX, STEP_S);

  // Per-frame update sequence; published outputs change only when leaving COMMIT.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_up     <= 1'b0;
      r_dn     <= 1'b0;
      r_lf     <= 1'b0;
      r_rt     <= 1'b0;
      r_auto   <= 1'b0;
      r_en_req <= 1'b0;
      r_x      <= 10'(X_INIT);
      r_y      <= 10'(Y_INIT);
      r_dir_x  <= 1'b1;
      r_dir_y  <= 1'b1;
      r_bnc    <= 1'b0;
      r_pos_x  <= 10'(X_INIT);
      r_pos_y  <= 10'(Y_INIT);
      r_enable <= 1'b0;
      r_color  <= SPR_COLOR_DEF;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_state <= ST_SAMPLE;
            r_busy  <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          r_up     <= iUp;
          r_dn     <= iDown;
          r_lf     <= iLeft;
          r_rt     <= iRight;
          r_auto   <= iAuto;
          r_en_req <= iEnableReq;
          r_state  <= ST_MOVE_X;
        end
        ST_MOVE_X: begin
          r_x   <= w_ax.pos;
          r_bnc <= w_ax.bnc;
          if (w_ax.bnc) r_dir_x <= ~r_dir_x;
          r_state <= ST_MOVE_Y;
        end
        ST_MOVE_Y: begin
          r_y   <= w_ay.pos;
          r_bnc <= r_bnc | w_ay.bnc;
          if (w_ay.bnc) r_dir_y <= ~r_dir_y;
          r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_pos_x  <= r_x;
          r_pos_y  <= r_y;
          r_enable <= r_en_req;
          if (r_bnc) r_color <= next_color(r_color, iColorBack);
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign oPosX        = r_pos_x;
  assign oPosY        = r_pos_y;
  assign oEnable      = r_enable;
  assign oColorSprite = r_color;
  assign oBusy        = r_busy;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: stimulus pushes expected frame
// results, a monitor pops and compares at each end of update sequence.
module tb_sprite_motion_ctrl;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [9:0] col = 10'd5, row = 10'd0;
  logic       up = 0, dn = 0, lf = 0, rt = 0, aut = 0, enq = 0;
  logic [2:0] back = 3'd5;

  logic [9:0] px, py, px2, py2;
  logic       pen, pbusy, pen2, pbusy2;
  logic [2:0] pcol, pcol2;

  sprite_motion_ctrl u_dut (
    .Clock(Clock), .Reset(Reset), .iColumnCount(col), .iRowCount(row),
    .iUp(up), .iDown(dn), .iLeft(lf), .iRight(rt), .iAuto(aut),
    .iEnableReq(enq), .iColorBack(back),
    .oPosX(px), .oPosY(py), .oEnable(pen), .oColorSprite(pcol), .oBusy(pbusy)
  );

  // Second instance starting at an odd X so the right-edge clamp is reachable.
  sprite_motion_ctrl #(.X_INIT(623)) u_dut2 (
    .Clock(Clock), .Reset(Reset), .iColumnCount(col), .iRowCount(row),
    .iUp(1'b0), .iDown(1'b0), .iLeft(1'b0), .iRight(1'b1), .iAuto(1'b0),
    .iEnableReq(1'b1), .iColorBack(3'd5),
    .oPosX(px2), .oPosY(py2), .oEnable(pen2), .oColorSprite(pcol2), .oBusy(pbusy2)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int en;
    int c;
  } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  int t_tick = 0;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, a, e);
    end
  endtask

  task automatic push(input int x, input int y, input int en, input int c);
    exp_t e;
    e.x = x; e.y = y; e.en = en; e.c = c;
    q.push_back(e);
  endtask

  // Monitor: compare at each busy falling edge, flag output changes elsewhere.
  initial begin
    logic        pb_prev;
    int          bcnt;
    logic [23:0] prev_o, cur_o;
    exp_t        e;
    pb_prev = 1'b0;
    bcnt    = 0;
    prev_o  = '0;
    forever begin
      @(negedge Clock);
      cur_o = {px, py, pen, pcol};
      if (!Reset) begin
        bcnt    = 0;
        pb_prev = 1'b0;
      end else begin
        if (pbusy) bcnt++;
        if (pb_prev && !pbusy) begin
          if (q.size() == 0) chk("unexpected_commit", 1, 0);
          else begin
            e = q.pop_front();
            chk("posx", int'(px), e.x);
            chk("posy", int'(py), e.y);
            chk("enable", int'(pen), e.en);
            chk("color", int'(pcol), e.c);
            chk("latency", cyc - t_tick, 5);
            chk("busy_cycles", bcnt, 4);
            chk("dut2_posx", int'(px2), 624);
            chk("dut2_posy", int'(py2), 232);
          end
          bcnt = 0;
        end else if (cur_o != prev_o) begin
          chk("output_change_outside_commit", int'(cur_o), int'(prev_o));
        end
        pb_prev = pbusy;
      end
      prev_o = cur_o;
    end
  end

  // mode 0 normal, 1 inputs change after sampling, 2 second tick while busy,
  // 3 reset pulse while in MOVE_Y.
  task automatic frame(input int mode);
    @(posedge Clock); #1;
    t_tick = cyc; row = 10'd480; col = 10'd0;          // cycle k
    @(posedge Clock); #1;                              // k+1: held counts
    if (mode == 2) row = 10'd0;
    @(posedge Clock); #1;                              // k+2
    row = (mode == 2) ? 10'd480 : 10'd0;
    if (mode == 1) begin rt = 1'b0; lf = 1'b1; end
    @(posedge Clock); #1;                              // k+3
    row = 10'd0; col = 10'd5;
    if (mode == 3) Reset = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;                              // k+5
    if (mode == 3) Reset = 1'b1;
    repeat (7) @(posedge Clock);
  endtask

  task automatic step(input int x, input int y, input int en, input int c);
    push(x, y, en, c);
    frame(0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_posx"}, int'(px), 312);
    chk({tag, "_posy"}, int'(py), 232);
    chk({tag, "_enable"}, int'(pen), 0);
    chk({tag, "_color"}, int'(pcol), 2);
    chk({tag, "_busy"}, int'(pbusy), 0);
    chk({tag, "_dut2_posx"}, int'(px2), 623);
  endtask

  initial begin
    int ex, ey;
    repeat (3) @(posedge Clock);
    #1 reset_vals("reset");
    Reset = 1'b1;
    repeat (6) @(posedge Clock);
    #1 reset_vals("post_release");

    // button right for three frames
    rt = 1; enq = 1;
    for (int i = 1; i <= 3; i++) step(312 + 2 * i, 232, 1, 2);

    // inputs changed after SAMPLE must not matter
    push(320, 232, 1, 2);
    frame(1);
    rt = 0; lf = 0;

    // opposing X buttons, up on Y
    lf = 1; rt = 1; up = 1;
    step(320, 230, 1, 2);

    // tick during busy ignored
    lf = 0; rt = 0; up = 0; dn = 1;
    push(320, 232, 1, 2);
    frame(2);

    // enable request dropped
    dn = 0; enq = 0;
    step(320, 232, 0, 2);

    // reset during MOVE_Y: no commit, then clean restart
    rt = 1; enq = 1;
    frame(3);
    reset_vals("mid_reset");
    step(314, 232, 1, 2);

    // walk left into the X=0 clamp and stay there
    rt = 0; lf = 1;
    ex = 314;
    for (int i = 0; i < 159; i++) begin
      ex = (ex >= 2) ? ex - 2 : 0;
      step(ex, 232, 1, 2);
    end

    // down to Y=462
    lf = 0; dn = 1;
    ey = 232;
    for (int i = 0; i < 115; i++) begin
      ey = ey + 2;
      step(0, ey, 1, 2);
    end

    // auto: bottom bounce, colour 2 -> 3
    dn = 0; aut = 1;
    step(2, 464, 1, 3);
    step(4, 462, 1, 3);

    // buttons up+right to (464,2), then right to X=620
    aut = 0; up = 1; rt = 1;
    ex = 4; ey = 462;
    for (int i = 0; i < 230; i++) begin
      ex = ex + 2; ey = ey - 2;
      step(ex, ey, 1, 3);
    end
    up = 0;
    for (int i = 0; i < 78; i++) begin
      ex = ex + 2;
      step(ex, 2, 1, 3);
    end

    // auto: top bounce (3->4), then right bounce (4->6, 5 is background)
    rt = 0; aut = 1;
    step(622, 0, 1, 4);
    step(624, 2, 1, 6);
    step(622, 4, 1, 6);

    // mode switch keeps position and direction flags
    aut = 0;
    step(622, 4, 1, 6);
    aut = 1;
    step(620, 6, 1, 6);

    repeat (10) @(posedge Clock);
    #1 chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
